// File: rtl/router_top.sv
// router_top: 1-to-3 byte-serial packet router.
// A header byte carries the payload length and a 2-bit destination address.
// The packet (header, payload, parity byte) is copied into one of three 16-deep
// output FIFOs, and each FIFO is drained by its own read enable. The received
// parity byte is compared with the XOR of header and payload, and the result is
// reported on err. A FIFO that holds data nobody reads for SOFT_RESET_CYCLES
// clocks is flushed. If that FIFO is the current target, the packet is abandoned.
module router_top #(
  parameter int FIFO_DEPTH        = 16,
  parameter int SOFT_RESET_CYCLES = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       packet_valid,
  input  logic [7:0] datain,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       busy,
  output logic       err
);

  localparam int NUM_PORTS = 3;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int SOFT_W    = $clog2(SOFT_RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Packet context, latched when the header is accepted
  logic [7:0] r_header;
  logic [1:0] r_addr;
  logic [7:0] r_calc_parity;
  logic [7:0] r_rx_parity;
  logic [7:0] r_hold;
  logic       r_hold_is_parity;
  logic       r_parity_seen;
  logic       r_err;

  // Per-FIFO status and control vectors, bit index = FIFO number
  logic [NUM_PORTS-1:0] w_rd_en;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_flush;
  logic [NUM_PORTS-1:0] w_sel;
  logic [NUM_PORTS-1:0] w_hdr_sel;
  logic [7:0]           w_dout [NUM_PORTS];

  logic       w_hdr_valid;
  logic       w_hdr_empty;
  logic       w_tgt_empty;
  logic       w_tgt_full;
  logic       w_tgt_flush;
  logic       w_wr_req;
  logic [7:0] w_wr_data;
  logic [7:0] w_rx_parity;

  assign w_rd_en = {read_enb_2, read_enb_1, read_enb_0};

  // One-hot decode of the latched target and of the address in the incoming byte
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_sel
      assign w_sel[gi]     = (r_addr == 2'(gi));
      assign w_hdr_sel[gi] = (datain[1:0] == 2'(gi));
    end
  endgenerate

  assign w_hdr_valid = packet_valid && (datain[1:0] != 2'd3);
  assign w_hdr_empty = |(w_empty & w_hdr_sel);
  assign w_tgt_empty = |(w_empty & w_sel);
  assign w_tgt_full  = |(w_full & w_sel);
  assign w_tgt_flush = |(w_flush & w_sel);

  // The parity byte reaches LOAD_PARITY uncaptured only after a stall on the last payload
  assign w_rx_parity = (r_state == LOAD_PARITY && !r_parity_seen) ? datain : r_rx_parity;

  assign busy = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
  assign err  = r_err;

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= DECODE_ADDRESS;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flushing the target FIFO abandons the packet in flight
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DECODE_ADDRESS: begin
        if (w_hdr_valid) begin
          w_state_next = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (w_tgt_empty) begin
          w_state_next = LOAD_FIRST_DATA;
        end
      end
      LOAD_FIRST_DATA: w_state_next = LOAD_DATA;
      LOAD_DATA: begin
        if (w_tgt_full) begin
          w_state_next = FIFO_FULL_STATE;
        end else if (!packet_valid) begin
          w_state_next = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!w_tgt_full) begin
          w_state_next = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (r_hold_is_parity) begin
          w_state_next = CHECK_PARITY_ERROR;
        end else if (packet_valid) begin
          w_state_next = LOAD_DATA;
        end else begin
          w_state_next = LOAD_PARITY;
        end
      end
      LOAD_PARITY:        w_state_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_state_next = DECODE_ADDRESS;
      default:            w_state_next = DECODE_ADDRESS;
    endcase
    if (r_state != DECODE_ADDRESS && w_tgt_flush) begin
      w_state_next = DECODE_ADDRESS;
    end
  end

  // Write request and data source toward the target FIFO
  always_comb begin
    w_wr_req  = 1'b0;
    w_wr_data = datain;
    case (r_state)
      LOAD_FIRST_DATA: begin
        w_wr_req  = 1'b1;
        w_wr_data = r_header;
      end
      LOAD_DATA: begin
        w_wr_req  = !w_tgt_full;
        w_wr_data = datain;
      end
      LOAD_AFTER_FULL: begin
        w_wr_req  = 1'b1;
        w_wr_data = r_hold;
      end
      default: begin
        w_wr_req  = 1'b0;
        w_wr_data = datain;
      end
    endcase
  end

  // Header latch, running parity, stall hold register and error flag
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_header         <= '0;
      r_addr           <= '0;
      r_calc_parity    <= '0;
      r_rx_parity      <= '0;
      r_hold           <= '0;
      r_hold_is_parity <= 1'b0;
      r_parity_seen    <= 1'b0;
      r_err            <= 1'b0;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (w_hdr_valid) begin
            r_header         <= datain;
            r_addr           <= datain[1:0];
            r_calc_parity    <= datain;
            r_hold_is_parity <= 1'b0;
            r_parity_seen    <= 1'b0;
            r_err            <= 1'b0;
          end
        end
        LOAD_DATA: begin
          // The byte is consumed here whether it is written now or held for later
          if (packet_valid) begin
            r_calc_parity <= r_calc_parity ^ datain;
          end else begin
            r_rx_parity   <= datain;
            r_parity_seen <= 1'b1;
          end
          if (w_tgt_full) begin
            r_hold           <= datain;
            r_hold_is_parity <= !packet_valid;
          end
        end
        LOAD_PARITY: begin
          if (!r_parity_seen) begin
            r_rx_parity   <= datain;
            r_parity_seen <= 1'b1;
          end
        end
        default: begin
          r_hold <= r_hold;
        end
      endcase
      if (w_state_next == CHECK_PARITY_ERROR && r_state != CHECK_PARITY_ERROR) begin
        r_err <= (w_rx_parity != r_calc_parity);
      end
    end
  end

  // Three identical output FIFOs, each with its own idle watchdog
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
      logic [7:0]        r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  r_wr_ptr;
      logic [PTR_W-1:0]  r_rd_ptr;
      logic [CNT_W-1:0]  r_count;
      logic [7:0]        r_dout;
      logic [SOFT_W-1:0] r_idle_cnt;
      logic              w_we;
      logic              w_re;

      assign w_empty[gi] = (r_count == '0);
      assign w_full[gi]  = (r_count == CNT_W'(FIFO_DEPTH));
      assign w_flush[gi] = !w_empty[gi] && !w_rd_en[gi] &&
                           (r_idle_cnt == SOFT_W'(SOFT_RESET_CYCLES - 1));
      assign w_we        = w_wr_req && w_sel[gi] && !w_full[gi] && !w_flush[gi];
      assign w_re        = w_rd_en[gi] && !w_empty[gi];
      assign w_dout[gi]  = r_dout;

      // Storage array, written only; no reset so it maps onto RAM
      always_ff @(posedge clk) begin
        if (w_we) begin
          r_mem[r_wr_ptr] <= w_wr_data;
        end
      end

      // Pointers, occupancy, registered read data and idle watchdog
      always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          r_count    <= '0;
          r_dout     <= '0;
          r_idle_cnt <= '0;
        end else if (w_flush[gi]) begin
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          r_count    <= '0;
          r_idle_cnt <= '0;
        end else begin
          if (w_we) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
          end
          if (w_re) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            r_dout   <= r_mem[r_rd_ptr];
          end
          case ({w_we, w_re})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
          if (!w_empty[gi] && !w_rd_en[gi]) begin
            r_idle_cnt <= r_idle_cnt + SOFT_W'(1);
          end else begin
            r_idle_cnt <= '0;
          end
        end
      end
    end
  endgenerate

  assign data_out_0 = w_dout[0];
  assign data_out_1 = w_dout[1];
  assign data_out_2 = w_dout[2];
  assign vld_out_0  = !w_empty[0];
  assign vld_out_1  = !w_empty[1];
  assign vld_out_2  = !w_empty[2];

endmodule

// File: tb/tb_router_top.sv
// tb_router_top: directed scenarios for the 1-to-3 packet router.
// Inputs change on the falling edge, and outputs are read on the falling edge.
module tb_router_top;

  logic       clk = 1'b0;
  logic       resetn;
  logic       packet_valid;
  logic [7:0] datain;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       busy, err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         pend0 = 1'b0;
  bit         pend1 = 1'b0;
  bit         v2_prev = 1'b0;
  int         v2_rise = 0;
  logic [7:0] last_par0;

  router_top #(.FIFO_DEPTH(16), .SOFT_RESET_CYCLES(30)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .packet_valid (packet_valid),
    .datain       (datain),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .data_out_0   (data_out_0),
    .data_out_1   (data_out_1),
    .data_out_2   (data_out_2),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record popped bytes of FIFO 0/1 and the cycle at which vld_out_2 rises
  always @(negedge clk) begin
    #1;
    if (pend0) q0.push_back(data_out_0);
    if (pend1) q1.push_back(data_out_1);
    pend0 = read_enb_0 && vld_out_0;
    pend1 = read_enb_1 && vld_out_1;
    if (vld_out_2 && !v2_prev) v2_rise = cyc;
    v2_prev = vld_out_2;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one byte and hold it until the router takes it (busy low at the edge)
  task automatic send(input logic pv, input logic [7:0] d);
    int g;
    g = 0;
    packet_valid = pv;
    datain = d;
    while (busy === 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_vec++; n_err++;
      $display("FAIL send_stall: busy=%b, required 0 within 200 cycles (byte %h)", busy, d);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_vec++; n_err++;
      $display("FAIL %s_idle: busy=%b, required 0 within 200 cycles", tag, busy);
    end
  endtask

  task automatic wait_vld_low(input int port, input string tag);
    int g;
    logic [2:0] v;
    g = 0;
    v = {vld_out_2, vld_out_1, vld_out_0};
    while (v[port] !== 1'b0 && g < 200) begin
      @(negedge clk);
      g++;
      v = {vld_out_2, vld_out_1, vld_out_0};
    end
    if (g >= 200) begin
      n_vec++; n_err++;
      $display("FAIL %s_drain: vld_out_%0d=%b, required 0 within 200 cycles", tag, port, v[port]);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; packet_valid = 1'b0; datain = 8'h00;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if ({vld_out_2, vld_out_1, vld_out_0} !== 3'b000) begin
      n_err++; $display("FAIL reset_vld: got %b want 000", {vld_out_2, vld_out_1, vld_out_0}); end
    n_vec++; if (data_out_0 !== 8'h00) begin n_err++; $display("FAIL reset_dout0: got %h want 00", data_out_0); end
    n_vec++; if (data_out_1 !== 8'h00) begin n_err++; $display("FAIL reset_dout1: got %h want 00", data_out_1); end
    n_vec++; if (data_out_2 !== 8'h00) begin n_err++; $display("FAIL reset_dout2: got %h want 00", data_out_2); end
    $display("test_reset done");
  endtask

  task automatic test_bad_parity();
    logic [7:0] pay [8];
    logic [7:0] par;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    read_enb_0 = 1'b1;
    par = 8'h20;
    send(1'b1, 8'h20);
    foreach (pay[i]) begin
      send(1'b1, pay[i]);
      par = par ^ pay[i];
    end
    send(1'b0, ~par);
    datain = 8'h00;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL badpar_busy_lp: got %b want 1", busy); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL badpar_busy_chk: got %b want 1", busy); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL badpar_busy_end: got %b want 0", busy); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL badpar_err: got %b want 1", err); end
    wait_vld_low(0, "badpar");
    @(negedge clk);
    read_enb_0 = 1'b0;
    @(negedge clk);
    $display("test_bad_parity done: sent parity %h (correct %h), err=%b", ~par, par, err);
  endtask

  task automatic test_good_parity();
    logic [7:0] pay [8];
    logic [7:0] par;
    logic [7:0] exp [$];
    pay = '{8'h3C, 8'hA5, 8'h0F, 8'h96, 8'h5A, 8'hC3, 8'h01, 8'hFE};
    q0.delete();
    par = 8'h20;
    exp.push_back(8'h20);
    send(1'b1, 8'h20);
    foreach (pay[i]) begin
      send(1'b1, pay[i]);
      par = par ^ pay[i];
      exp.push_back(pay[i]);
    end
    send(1'b0, par);
    exp.push_back(par);
    datain = 8'h00;
    wait_idle("goodpar");
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL goodpar_err: got %b want 0", err); end
    read_enb_0 = 1'b1;
    wait_vld_low(0, "goodpar");
    @(negedge clk);
    read_enb_0 = 1'b0;
    @(negedge clk);
    n_vec++; if (q0.size() != exp.size()) begin
      n_err++; $display("FAIL goodpar_count: got %0d bytes want %0d", q0.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
      n_vec++; if (q0[i] !== exp[i]) begin
        n_err++; $display("FAIL goodpar_byte%0d: got %h want %h", i, q0[i], exp[i]); end
    end
    last_par0 = par;
    $display("test_good_parity done: %0d bytes popped, parity %h", q0.size(), par);
  endtask

  task automatic test_invalid_addr();
    logic [7:0] bytes [3];
    bytes = '{8'h0B, 8'hFF, 8'h13};
    foreach (bytes[i]) begin
      packet_valid = 1'b1;
      datain = bytes[i];
      @(negedge clk);
      n_vec++; if ({busy, err, vld_out_2, vld_out_1, vld_out_0} !== 5'b00000) begin
        n_err++; $display("FAIL invaddr_byte%0d: busy,err,vld2..0 got %b want 00000", i,
                          {busy, err, vld_out_2, vld_out_1, vld_out_0}); end
    end
    packet_valid = 1'b0;
    datain = 8'h0B ^ 8'hFF ^ 8'h13;
    @(negedge clk);
    n_vec++; if ({busy, err, vld_out_2, vld_out_1, vld_out_0} !== 5'b00000) begin
      n_err++; $display("FAIL invaddr_parity: busy,err,vld2..0 got %b want 00000",
                        {busy, err, vld_out_2, vld_out_1, vld_out_0}); end
    datain = 8'h00;
    @(negedge clk);
    $display("test_invalid_addr done");
  endtask

  task automatic test_fifo_full();
    logic [7:0] pay [20];
    logic [7:0] par;
    logic [7:0] exp [$];
    for (int i = 0; i < 20; i++) pay[i] = 8'((i * 37 + 11) & 255);
    q1.delete();
    read_enb_1 = 1'b0;
    par = 8'h51;
    exp.push_back(8'h51);
    send(1'b1, 8'h51);
    for (int i = 0; i < 16; i++) begin
      send(1'b1, pay[i]);
      par = par ^ pay[i];
      exp.push_back(pay[i]);
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy); end
    n_vec++; if (vld_out_1 !== 1'b1) begin n_err++; $display("FAIL full_vld1: got %b want 1", vld_out_1); end
    packet_valid = 1'b1;
    datain = pay[16];
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy_hold: got %b want 1", busy); end
    read_enb_1 = 1'b1;
    for (int i = 16; i < 20; i++) begin
      send(1'b1, pay[i]);
      par = par ^ pay[i];
      exp.push_back(pay[i]);
    end
    send(1'b0, par);
    exp.push_back(par);
    datain = 8'h00;
    wait_idle("full");
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", err); end
    wait_vld_low(1, "full");
    @(negedge clk);
    read_enb_1 = 1'b0;
    @(negedge clk);
    n_vec++; if (q1.size() != exp.size()) begin
      n_err++; $display("FAIL full_count: got %0d bytes want %0d", q1.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q1.size(); i++) begin
      n_vec++; if (q1[i] !== exp[i]) begin
        n_err++; $display("FAIL full_byte%0d: got %h want %h", i, q1[i], exp[i]); end
    end
    $display("test_fifo_full done: %0d bytes popped from FIFO 1", q1.size());
  endtask

  task automatic test_soft_reset();
    logic [7:0] pay [4];
    logic [7:0] par;
    int g;
    pay = '{8'h21, 8'h42, 8'h84, 8'h18};
    read_enb_2 = 1'b0;
    par = 8'h12;
    send(1'b1, 8'h12);
    foreach (pay[i]) begin
      send(1'b1, pay[i]);
      par = par ^ pay[i];
    end
    send(1'b0, par);
    datain = 8'h00;
    n_vec++; if (vld_out_2 !== 1'b1) begin n_err++; $display("FAIL soft_vld_before: got %b want 1", vld_out_2); end
    g = 0;
    while (vld_out_2 !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    n_vec++; if (vld_out_2 !== 1'b0) begin n_err++; $display("FAIL soft_flush: vld_out_2 got %b want 0", vld_out_2); end
    n_vec++; if (cyc - v2_rise != 30) begin
      n_err++; $display("FAIL soft_cycles: vld_out_2 high %0d cycles want 30", cyc - v2_rise); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL soft_busy: got %b want 0", busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL soft_err: got %b want 0", err); end
    $display("test_soft_reset done: vld_out_2 high for %0d cycles", cyc - v2_rise);
  endtask

  task automatic test_mid_packet_reset();
    logic [7:0] exp [3];
    exp = '{8'h04, 8'hA5, 8'hA1};
    read_enb_0 = 1'b0;
    n_vec++; if (data_out_0 !== last_par0) begin
      n_err++; $display("FAIL midrst_dout_hold: got %h want %h", data_out_0, last_par0); end
    send(1'b1, 8'h10);
    send(1'b1, 8'h5A);
    send(1'b1, 8'h6B);
    n_vec++; if (vld_out_0 !== 1'b1) begin n_err++; $display("FAIL midrst_vld_before: got %b want 1", vld_out_0); end
    #2;
    resetn = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (vld_out_0 !== 1'b0) begin n_err++; $display("FAIL midrst_vld0: got %b want 0", vld_out_0); end
    n_vec++; if (data_out_0 !== 8'h00) begin n_err++; $display("FAIL midrst_dout0: got %h want 00", data_out_0); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b want 0", err); end
    packet_valid = 1'b0;
    datain = 8'h00;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    q0.delete();
    send(1'b1, 8'h04);
    send(1'b1, 8'hA5);
    send(1'b0, 8'hA1);
    datain = 8'h00;
    wait_idle("midrst");
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL midrst_new_err: got %b want 0", err); end
    read_enb_0 = 1'b1;
    wait_vld_low(0, "midrst");
    @(negedge clk);
    read_enb_0 = 1'b0;
    @(negedge clk);
    n_vec++; if (q0.size() != 3) begin n_err++; $display("FAIL midrst_count: got %0d bytes want 3", q0.size()); end
    for (int i = 0; i < 3 && i < q0.size(); i++) begin
      n_vec++; if (q0[i] !== exp[i]) begin
        n_err++; $display("FAIL midrst_byte%0d: got %h want %h", i, q0[i], exp[i]); end
    end
    $display("test_mid_packet_reset done: %0d bytes popped after reset", q0.size());
  endtask

  initial begin
    test_reset();
    test_bad_parity();
    test_good_parity();
    test_invalid_addr();
    test_fifo_full();
    test_soft_reset();
    test_mid_packet_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/router_top.md
Name: router_top

Overview:
- 1-to-3 packet router. Byte-serial packets on `datain` are steered by a 2-bit header address into one of three output FIFOs; each FIFO is drained independently by its own read enable.
- Sits between a single packet source (flow-controlled by `busy`) and three destination clients.
- Checks packet parity and flags mismatches on `err`.

Parameters:
- FIFO_DEPTH, 16, entries per output FIFO (8-bit words).
- SOFT_RESET_CYCLES, 30, consecutive unread-valid cycles before a FIFO is auto-flushed.

Ports:
- clk  input  1  single clock, all logic on its rising edge.
- resetn  input  1  asynchronous, active-high reset.
- packet_valid  input  1  high while header and payload bytes are driven; low on the parity byte.
- datain  input  8  packet byte stream.
- read_enb_0 / read_enb_1 / read_enb_2  input  1 each  pop request for FIFO 0/1/2.
- data_out_0 / data_out_1 / data_out_2  output  8 each  popped byte.
- vld_out_0 / vld_out_1 / vld_out_2  output  1 each  FIFO x non-empty.
- busy  output  1  source must hold `datain`/`packet_valid` while high.
- err  output  1  parity mismatch on last packet.

Behaviour:
- Packet format:
  - Header byte: [7:2] payload length L (1..63), [1:0] address (0,1,2 valid; 3 invalid).
  - Then L payload bytes with `packet_valid`=1.
  - Then one parity byte, presented in the first cycle `packet_valid`=0.
  - Parity = XOR of header and all payload bytes.
- Reset (async, `resetn`=1):
  - FIFOs emptied; `data_out_x`=0, `vld_out_x`=0.
  - `busy`=0, `err`=0, FSM in DECODE_ADDRESS.
  - Parity/header registers cleared.
- FSM states:
  - DECODE_ADDRESS (`busy`=0):
    - On `packet_valid`=1 with address 0..2, latch header.
    - If target FIFO empty: go to LOAD_FIRST_DATA.
    - If target FIFO non-empty: go to WAIT_TILL_EMPTY.
    - Address 3: byte ignored, stay.
  - WAIT_TILL_EMPTY (`busy`=1): go to LOAD_FIRST_DATA once target FIFO empty.
  - LOAD_FIRST_DATA (`busy`=1): write latched header to target FIFO; go to LOAD_DATA.
  - LOAD_DATA (`busy`=0):
    - Each cycle write `datain` to target FIFO and XOR it into the running parity.
    - If `packet_valid`=0: the byte is the parity byte; write it, capture it as received parity, go to LOAD_PARITY.
    - If the target FIFO is full: do not write; capture `datain` into a hold register; go to FIFO_FULL_STATE.
  - FIFO_FULL_STATE (`busy`=1): go to LOAD_AFTER_FULL when target FIFO not full.
  - LOAD_AFTER_FULL (`busy`=1): write the held byte; then:
    - If the held byte was parity: go to CHECK_PARITY_ERROR.
    - Else if `packet_valid`=1: go to LOAD_DATA.
    - Else: go to LOAD_PARITY.
  - LOAD_PARITY (`busy`=1): no write; go to CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR (`busy`=1):
    - `err` becomes 1 on entry if received parity differs from computed parity.
    - Go to DECODE_ADDRESS.
- `err` holds until reset or the next valid header is latched; it is then cleared.
- FIFOs:
  - 16 x 8, synchronous write/read.
  - Simultaneous read and write allowed.
  - Write when full ignored; read when empty ignored (`data_out_x` holds).
  - `data_out_x` updates one cycle after `read_enb_x`=1 with FIFO non-empty.
  - `vld_out_x` = not empty (combinational).
  - Pointers wrap modulo 16.
- Soft reset: if `vld_out_x`=1 and `read_enb_x`=0 for SOFT_RESET_CYCLES consecutive clocks, FIFO x is flushed. If FIFO x is the current target, the FSM returns to DECODE_ADDRESS, abandoning the packet.
- Only one packet in flight at a time; reads from other FIFOs proceed concurrently.

Test Plan:
- Reset, header 0x20 (L=8, addr 0), 8 random payloads, then parity byte = bitwise NOT of the correct XOR with `packet_valid`=0, `read_enb_0`=1 -> `busy`=1 in LOAD_PARITY/CHECK_PARITY_ERROR, then 0; `err`=1 after `busy` falls.
- Same packet with correct parity -> `err`=0; `data_out_0` yields 0x20, the 8 payloads, then parity, in order.
- Header 0x0B (L=2, addr 3) -> ignored; no `vld_out_x` rises; FSM stays in DECODE_ADDRESS; `busy`=0.
- Packet L=20 to addr 1 with `read_enb_1`=0 -> after 16 writes `busy`=1 (FIFO_FULL_STATE). Asserting `read_enb_1` -> remaining bytes accepted, no data lost.
- Packet L=4 to addr 2, `read_enb_2` held 0 -> after 30 cycles of `vld_out_2`=1, FIFO 2 flushed and `vld_out_2`=0.
- Assert `resetn` mid-packet -> all outputs 0 immediately; next header accepted normally.
